// File: rtl/ee194_radio_core_if.sv
`timescale 1ns/1ps
// JTAG pin bundle for ee194_radio_core; the pins are oversampled in the core clock domain.
interface ee194_radio_core_if;
  logic TCK;
  logic TMS;
  logic TDI;
  logic TRSTn;
  logic TDO;

  modport master (output TCK, TMS, TDI, TRSTn, input TDO);
  modport slave  (input TCK, TMS, TDI, TRSTn, output TDO);
endinterface

// File: rtl/ee194_radio_core.sv
`timescale 1ns/1ps
// EE194 radio digital top: oversampled JTAG TAP (IDCODE/CTRL/STATUS/BYPASS), 8N1 UART transmitter,
// and a 3-bit GFSK symbol modulator with a combinational bypass path; all in the system clock domain.
module ee194_radio_core #(
  parameter logic [31:0] IDCODE   = 32'h1E19_4001,
  parameter int          UART_DIV = 87,
  parameter int          SYM_DIV  = 10
) (
  input  logic               clock,
  input  logic               reset,
  ee194_radio_core_if.slave  io_jtag,
  output logic               io_uart_txd,
  input  logic               io_uart_rxd,
  input  logic [4:0]         io_isig,
  input  logic [4:0]         io_qsig,
  output logic [2:0]         io_gfskout,
  input  logic               io_modulator_bypass_force,
  input  logic               io_alternate_modulation_in
);

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_CTRL   = 5'h10;
  localparam logic [4:0] IR_STATUS = 5'h11;
  localparam int         UCW       = $clog2(UART_DIV);
  localparam int         MCW       = $clog2(SYM_DIV);

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
  } tap_state_t;

  logic [2:0]  r_tck_s;
  logic [1:0]  r_tms_s, r_tdi_s, r_trst_s, r_rxd_s;
  tap_state_t  r_state;
  logic [4:0]  r_ir, r_ir_sr;
  logic [31:0] r_dr_sr, r_ctrl;
  logic        r_tdo, r_upd_dr;

  logic            r_uart_busy, r_txd;
  logic [UCW-1:0]  r_uart_cnt;
  logic [3:0]      r_uart_bits;
  logic [8:0]      r_uart_sr;

  logic            r_mod_busy;
  logic [MCW-1:0]  r_mod_cnt;
  logic [4:0]      r_mod_slot;
  logic [16:0]     r_mod_sr;
  logic [2:0]      r_h;

  logic        w_tck_rise, w_tck_fall, w_tms, w_tdi, w_trst, w_dr_len32;
  logic        w_upd_ctrl, w_tx_start, w_mod_start;
  logic [31:0] w_status, w_capture;
  logic [2:0]  w_gfsk;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tck_s  <= '0;
      r_tms_s  <= '0;
      r_tdi_s  <= '0;
      r_trst_s <= '0;
      r_rxd_s  <= 2'b11;
    end else begin
      r_tck_s  <= {r_tck_s[1:0], io_jtag.TCK};
      r_tms_s  <= {r_tms_s[0], io_jtag.TMS};
      r_tdi_s  <= {r_tdi_s[0], io_jtag.TDI};
      r_trst_s <= {r_trst_s[0], io_jtag.TRSTn};
      r_rxd_s  <= {r_rxd_s[0], io_uart_rxd};
    end
  end

  assign w_tck_rise = r_tck_s[1] & ~r_tck_s[2];
  assign w_tck_fall = ~r_tck_s[1] & r_tck_s[2];
  assign w_tms      = r_tms_s[1];
  assign w_tdi      = r_tdi_s[1];
  assign w_trst     = ~r_trst_s[1];
  assign w_dr_len32 = (r_ir == IR_IDCODE) || (r_ir == IR_CTRL) || (r_ir == IR_STATUS);
  assign w_status   = {19'b0, r_rxd_s[1], r_mod_busy, r_uart_busy, io_qsig, io_isig};

  always_comb begin
    w_capture = 32'h0;
    case (r_ir)
      IR_IDCODE: w_capture = IDCODE;
      IR_CTRL:   w_capture = r_ctrl;
      IR_STATUS: w_capture = w_status;
      default:   w_capture = 32'h0;
    endcase
  end

  // Update-DR side effects fire one clock after the TAP enters Update-DR.
  assign w_upd_ctrl  = r_upd_dr && (r_ir == IR_CTRL);
  assign w_tx_start  = w_upd_ctrl && r_dr_sr[8] && !r_uart_busy;
  assign w_mod_start = w_upd_ctrl && r_dr_sr[9] && !r_mod_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_TLR;
      r_ir     <= IR_IDCODE;
      r_ir_sr  <= '0;
      r_dr_sr  <= '0;
      r_tdo    <= 1'b0;
      r_upd_dr <= 1'b0;
      r_ctrl   <= '0;
    end else begin
      r_upd_dr <= 1'b0;
      if (w_upd_ctrl) r_ctrl <= {r_dr_sr[31:10], 2'b00, r_dr_sr[7:0]};
      if (w_trst) begin
        r_state <= S_TLR;
        r_ir    <= IR_IDCODE;
      end else begin
        if (r_state == S_TLR) r_ir <= IR_IDCODE;
        if (w_tck_fall) begin
          r_tdo <= (r_state == S_SH_DR) ? r_dr_sr[0] :
                   (r_state == S_SH_IR) ? r_ir_sr[0] : 1'b0;
        end
        if (w_tck_rise) begin
          case (r_state)
            S_TLR:    r_state <= w_tms ? S_TLR : S_RTI;
            S_RTI:    r_state <= w_tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: r_state <= w_tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: begin
              r_dr_sr <= w_capture;
              r_state <= w_tms ? S_EX1_DR : S_SH_DR;
            end
            S_SH_DR: begin
              r_dr_sr <= w_dr_len32 ? {w_tdi, r_dr_sr[31:1]} : {31'b0, w_tdi};
              r_state <= w_tms ? S_EX1_DR : S_SH_DR;
            end
            S_EX1_DR: begin
              r_upd_dr <= w_tms;
              r_state  <= w_tms ? S_UPD_DR : S_PAU_DR;
            end
            S_PAU_DR: r_state <= w_tms ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: begin
              r_upd_dr <= w_tms;
              r_state  <= w_tms ? S_UPD_DR : S_SH_DR;
            end
            S_UPD_DR: r_state <= w_tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: r_state <= w_tms ? S_TLR : S_CAP_IR;
            S_CAP_IR: begin
              r_ir_sr <= 5'b00001;
              r_state <= w_tms ? S_EX1_IR : S_SH_IR;
            end
            S_SH_IR: begin
              r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
              r_state <= w_tms ? S_EX1_IR : S_SH_IR;
            end
            S_EX1_IR: begin
              if (w_tms) r_ir <= r_ir_sr;
              r_state <= w_tms ? S_UPD_IR : S_PAU_IR;
            end
            S_PAU_IR: r_state <= w_tms ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: begin
              if (w_tms) r_ir <= r_ir_sr;
              r_state <= w_tms ? S_UPD_IR : S_SH_IR;
            end
            S_UPD_IR: r_state <= w_tms ? S_SEL_DR : S_RTI;
            default:  r_state <= S_TLR;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_uart_busy <= 1'b0;
      r_txd       <= 1'b1;
      r_uart_cnt  <= '0;
      r_uart_bits <= '0;
      r_uart_sr   <= '1;
    end else if (w_tx_start) begin
      r_uart_busy <= 1'b1;
      r_txd       <= 1'b0;
      r_uart_cnt  <= '0;
      r_uart_bits <= '0;
      r_uart_sr   <= {1'b1, r_dr_sr[7:0]};
    end else if (r_uart_busy) begin
      if (r_uart_cnt == UCW'(UART_DIV - 1)) begin
        r_uart_cnt <= '0;
        if (r_uart_bits == 4'd9) begin
          r_uart_busy <= 1'b0;
          r_txd       <= 1'b1;
        end else begin
          r_txd       <= r_uart_sr[0];
          r_uart_sr   <= {1'b1, r_uart_sr[8:1]};
          r_uart_bits <= r_uart_bits + 1'b1;
        end
      end else begin
        r_uart_cnt <= r_uart_cnt + 1'b1;
      end
    end
  end

  // Payload bit 0 enters the history on the start clock; the rest plus two flush zeros follow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mod_busy <= 1'b0;
      r_mod_cnt  <= '0;
      r_mod_slot <= '0;
      r_mod_sr   <= '0;
      r_h        <= '0;
    end else if (w_mod_start) begin
      r_mod_busy <= 1'b1;
      r_mod_cnt  <= '0;
      r_mod_slot <= 5'd1;
      r_mod_sr   <= {2'b00, r_dr_sr[31:17]};
      r_h        <= {2'b00, r_dr_sr[16]};
    end else if (r_mod_busy) begin
      if (r_mod_cnt == MCW'(SYM_DIV - 1)) begin
        r_mod_cnt <= '0;
        if (r_mod_slot == 5'd18) begin
          r_mod_busy <= 1'b0;
          r_h        <= '0;
        end else begin
          r_h        <= {r_h[1:0], r_mod_sr[0]};
          r_mod_sr   <= {1'b0, r_mod_sr[16:1]};
          r_mod_slot <= r_mod_slot + 1'b1;
        end
      end else begin
        r_mod_cnt <= r_mod_cnt + 1'b1;
      end
    end
  end

  assign w_gfsk = (r_h[2] ? 3'd2 : 3'd0) + (r_h[1] ? 3'd3 : 3'd0) + (r_h[0] ? 3'd2 : 3'd0);

  assign io_gfskout  = (r_ctrl[10] || io_modulator_bypass_force) ?
                       {3{io_alternate_modulation_in}} : w_gfsk;
  assign io_uart_txd = r_txd;
  assign io_jtag.TDO = r_tdo;

endmodule

// File: tb/tb_ee194_radio_core.sv
`timescale 1ns/1ps
// Bench for ee194_radio_core: bit-bangs JTAG slowly against the oversampler and compares TAP reads,
// UART frame traces and GFSK level traces with a behavioural model of the frame/symbol rules.
module tb_ee194_radio_core;
  localparam logic [31:0] IDC  = 32'h1E19_4001;
  localparam int          UDIV = 87;
  localparam int          SDIV = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        txd, rxd;
  logic [4:0]  isig, qsig;
  logic [2:0]  gfsk;
  logic        byp_force, alt_in;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_ctrl;
  logic        uart_trace [0:10*UDIV-1];
  logic [2:0]  mod_trace [0:18*SDIV+9];
  bit          uart_found, mod_found;

  ee194_radio_core_if jtag();

  ee194_radio_core dut (
    .clock                      (clock),
    .reset                      (reset),
    .io_jtag                    (jtag),
    .io_uart_txd                (txd),
    .io_uart_rxd                (rxd),
    .io_isig                    (isig),
    .io_qsig                    (qsig),
    .io_gfskout                 (gfsk),
    .io_modulator_bypass_force  (byp_force),
    .io_alternate_modulation_in (alt_in)
  );

  always #50 clock = ~clock;

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d n_err=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // One TCK period; returns TDO as seen after the falling edge has propagated.
  task automatic tck(input logic tms, input logic tdi, output logic tdo);
    @(negedge clock);
    jtag.TMS = tms;
    jtag.TDI = tdi;
    repeat (4) @(negedge clock);
    jtag.TCK = 1'b1;
    repeat (4) @(negedge clock);
    jtag.TCK = 1'b0;
    repeat (4) @(negedge clock);
    tdo = jtag.TDO;
  endtask

  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic t;
    dout = '0;
    tck(1'b1, 1'b0, t);
    tck(1'b0, 1'b0, t);
    tck(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      dout[i] = t;
      tck(i == n - 1, din[i], t);
    end
    tck(1'b1, 1'b0, t);
    tck(1'b0, 1'b0, t);
  endtask

  task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
    logic t;
    dout = '0;
    tck(1'b1, 1'b0, t);
    tck(1'b1, 1'b0, t);
    tck(1'b0, 1'b0, t);
    tck(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      dout[i] = t;
      tck(i == 4, din[i], t);
    end
    tck(1'b1, 1'b0, t);
    tck(1'b0, 1'b0, t);
  endtask

  task automatic uart_capture();
    int waited = 0;
    uart_found = 1'b0;
    while (txd !== 1'b0 && waited < 4000) begin
      @(negedge clock);
      waited++;
    end
    if (txd === 1'b0) begin
      uart_found = 1'b1;
      for (int c = 0; c < 10*UDIV; c++) begin
        uart_trace[c] = txd;
        @(negedge clock);
      end
    end
  endtask

  task automatic mod_capture();
    int waited = 0;
    mod_found = 1'b0;
    while (gfsk === 3'd0 && waited < 4000) begin
      @(negedge clock);
      waited++;
    end
    if (gfsk !== 3'd0) begin
      mod_found = 1'b1;
      for (int c = 0; c < 18*SDIV+10; c++) begin
        mod_trace[c] = gfsk;
        @(negedge clock);
      end
    end
  endtask

  function automatic int pbit(input logic [15:0] p, input int j);
    return (j >= 0 && j < 16) ? int'(p[j]) : 0;
  endfunction

  task automatic test_reset();
    logic t;
    jtag.TCK = 1'b0; jtag.TMS = 1'b1; jtag.TDI = 1'b0; jtag.TRSTn = 1'b1;
    rxd = 1'b1; isig = '0; qsig = '0; byp_force = 1'b0; alt_in = 1'b0;
    m_ctrl = '0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, t);
    n_vec++; if (t !== 1'b0) begin n_err++; $display("FAIL reset_tdo: got %b want 0", t); end
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_vec++; if (gfsk !== 3'd0) begin n_err++; $display("FAIL reset_gfsk: got %0d want 0", gfsk); end
    tck(1'b0, 1'b0, t);
  endtask

  task automatic test_idcode();
    logic [31:0] d;
    logic [4:0]  ir;
    shift_dr(32'h0, 32, d);
    n_vec++; if (d !== IDC) begin n_err++; $display("FAIL idcode: got %h want %h", d, IDC); end
    shift_ir(5'h10, ir);
    n_vec++; if (ir !== 5'b00001) begin n_err++; $display("FAIL ir_capture: got %b want 00001", ir); end
    shift_dr(32'h0, 32, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_reset: got %h want 0", d); end
  endtask

  task automatic test_ctrl_rw();
    logic [31:0] d, v;
    for (int i = 0; i < 3; i++) begin
      v = $urandom & 32'hFFFF_F8FF;
      shift_dr(v, 32, d);
      n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL ctrl_rw%0d: got %h want %h", i, d, m_ctrl); end
      m_ctrl = v;
    end
    shift_dr(32'h0, 32, d);
    n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL ctrl_rw_last: got %h want %h", d, m_ctrl); end
    m_ctrl = '0;
  endtask

  task automatic test_bypass_reg();
    logic [31:0] d, din;
    logic [4:0]  ir;
    logic [4:0]  codes [2];
    codes[0] = 5'h1F;
    codes[1] = 5'h05;
    for (int c = 0; c < 2; c++) begin
      shift_ir(codes[c], ir);
      for (int i = 0; i < 2; i++) begin
        din = (c == 0 && i == 0) ? 32'hA5 : ($urandom & 32'hFF);
        shift_dr(din, 8, d);
        n_vec++;
        if (d[7:0] !== {din[6:0], 1'b0}) begin
          n_err++; $display("FAIL bypass_ir%h: got %h want %h", codes[c], d[7:0], {din[6:0], 1'b0});
        end
      end
    end
    shift_ir(5'h10, ir);
  endtask

  task automatic test_uart();
    logic [31:0] d;
    logic [9:0]  frame;
    int          good, lows;
    fork
      begin
        shift_dr(32'h155, 32, d);
        n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL uart_wr1: got %h want %h", d, m_ctrl); end
        m_ctrl = 32'h55;
        shift_dr(32'h1AA, 32, d);
        n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL uart_go_clear: got %h want %h", d, m_ctrl); end
        m_ctrl = 32'hAA;
      end
      uart_capture();
    join
    frame = {1'b1, 8'h55, 1'b0};
    n_vec++;
    if (!uart_found) begin
      n_err++; $display("FAIL uart_start: no start bit seen, got none want 1");
    end else begin
      for (int k = 0; k < 10; k++) begin
        good = 0;
        for (int c = 0; c < UDIV; c++) if (uart_trace[k*UDIV+c] === frame[k]) good++;
        n_vec++;
        if (good !== UDIV) begin n_err++; $display("FAIL uart_bit%0d: %0d samples ok want %0d", k, good, UDIV); end
      end
    end
    lows = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (txd !== 1'b1) lows++;
    end
    n_vec++; if (lows !== 0) begin n_err++; $display("FAIL uart_ignored_go: %0d low samples want 0", lows); end
  endtask

  task automatic test_status();
    logic [31:0] d, exp;
    logic [4:0]  ir;
    logic [7:0]  b;
    logic [9:0]  frame;
    int          good;
    b = 8'($urandom);
    isig = 5'($urandom);
    qsig = 5'($urandom);
    rxd = 1'($urandom);
    fork
      begin
        shift_dr({24'h0, b} | 32'h100, 32, d);
        n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL status_wr: got %h want %h", d, m_ctrl); end
        m_ctrl = {24'h0, b};
        shift_ir(5'h11, ir);
        shift_dr(32'h0, 32, d);
        exp = {19'b0, rxd, 1'b0, 1'b1, qsig, isig};
        n_vec++; if (d !== exp) begin n_err++; $display("FAIL status_busy: got %h want %h", d, exp); end
      end
      uart_capture();
    join
    frame = {1'b1, b, 1'b0};
    n_vec++;
    if (!uart_found) begin
      n_err++; $display("FAIL status_uart_start: no start bit seen, got none want 1");
    end else begin
      for (int k = 0; k < 10; k++) begin
        good = 0;
        for (int c = 0; c < UDIV; c++) if (uart_trace[k*UDIV+c] === frame[k]) good++;
        n_vec++;
        if (good !== UDIV) begin n_err++; $display("FAIL status_uart_bit%0d: %0d ok want %0d", k, good, UDIV); end
      end
    end
    repeat (20) @(negedge clock);
    shift_dr(32'h0, 32, d);
    exp = {19'b0, rxd, 1'b0, 1'b0, qsig, isig};
    n_vec++; if (d !== exp) begin n_err++; $display("FAIL status_idle: got %h want %h", d, exp); end
    shift_ir(5'h10, ir);
  endtask

  task automatic test_modulator();
    logic [31:0] d, exp;
    logic [4:0]  ir;
    int          lvl, good;
    fork
      begin
        shift_dr(32'h0001_0200, 32, d);
        n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL mod_wr: got %h want %h", d, m_ctrl); end
        m_ctrl = 32'h0001_0000;
      end
      mod_capture();
    join
    n_vec++;
    if (!mod_found) begin
      n_err++; $display("FAIL mod_start: no nonzero level seen, got none want 1");
    end else begin
      for (int k = 0; k < 19; k++) begin
        lvl = (k < 18) ? 2*pbit(16'h0001, k-2) + 3*pbit(16'h0001, k-1) + 2*pbit(16'h0001, k) : 0;
        good = 0;
        for (int c = 0; c < SDIV; c++) if (mod_trace[k*SDIV+c] === 3'(lvl)) good++;
        n_vec++;
        if (good !== SDIV) begin n_err++; $display("FAIL mod_slot%0d: %0d ok want %0d at level %0d", k, good, SDIV, lvl); end
      end
    end
    shift_ir(5'h11, ir);
    shift_dr(32'h0, 32, d);
    exp = {19'b0, rxd, 1'b0, 1'b0, qsig, isig};
    n_vec++; if (d !== exp) begin n_err++; $display("FAIL mod_busy_clear: got %h want %h", d, exp); end
    shift_ir(5'h10, ir);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic [15:0] p;
    logic [7:0]  b;
    logic [9:0]  frame;
    int          lvl, good;
    p = 16'($urandom) | 16'h0001;
    b = 8'($urandom);
    fork
      begin
        shift_dr({p, 8'h03, b}, 32, d);
        n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL both_wr: got %h want %h", d, m_ctrl); end
        m_ctrl = {p, 8'h00, b};
      end
      uart_capture();
      mod_capture();
    join
    frame = {1'b1, b, 1'b0};
    n_vec++;
    if (!uart_found) begin
      n_err++; $display("FAIL both_uart_start: no start bit seen, got none want 1");
    end else begin
      for (int k = 0; k < 10; k++) begin
        good = 0;
        for (int c = 0; c < UDIV; c++) if (uart_trace[k*UDIV+c] === frame[k]) good++;
        n_vec++;
        if (good !== UDIV) begin n_err++; $display("FAIL both_uart_bit%0d: %0d ok want %0d", k, good, UDIV); end
      end
    end
    n_vec++;
    if (!mod_found) begin
      n_err++; $display("FAIL both_mod_start: no nonzero level seen, got none want 1");
    end else begin
      for (int k = 0; k < 19; k++) begin
        lvl = (k < 18) ? 2*pbit(p, k-2) + 3*pbit(p, k-1) + 2*pbit(p, k) : 0;
        good = 0;
        for (int c = 0; c < SDIV; c++) if (mod_trace[k*SDIV+c] === 3'(lvl)) good++;
        n_vec++;
        if (good !== SDIV) begin n_err++; $display("FAIL both_mod_slot%0d: %0d ok want %0d at level %0d", k, good, SDIV, lvl); end
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    logic        a;
    byp_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a = (i < 2) ? 1'(i == 0) : 1'($urandom);
      alt_in = a;
      #1;
      n_vec++; if (gfsk !== (a ? 3'd7 : 3'd0)) begin n_err++; $display("FAIL bypass_force%0d: got %0d want %0d", i, gfsk, a ? 7 : 0); end
    end
    byp_force = 1'b0;
    shift_dr(32'h400, 32, d);
    m_ctrl = 32'h400;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      a = 1'(i == 0);
      alt_in = a;
      #1;
      n_vec++; if (gfsk !== (a ? 3'd7 : 3'd0)) begin n_err++; $display("FAIL bypass_ctrl%0d: got %0d want %0d", i, gfsk, a ? 7 : 0); end
    end
    shift_dr(32'h0, 32, d);
    m_ctrl = '0;
    @(negedge clock);
    alt_in = 1'b1;
    #1;
    n_vec++; if (gfsk !== 3'd0) begin n_err++; $display("FAIL bypass_off: got %0d want 0", gfsk); end
    alt_in = 1'b0;
  endtask

  task automatic test_trstn();
    logic [31:0] d, v;
    logic [4:0]  ir;
    logic        t;
    v = $urandom & 32'hFFFF_F8FF;
    shift_dr(v, 32, d);
    m_ctrl = v;
    shift_ir(5'h1F, ir);
    tck(1'b1, 1'b0, t);
    tck(1'b0, 1'b0, t);
    tck(1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) tck(1'b0, 1'b1, t);
    jtag.TRSTn = 1'b0;
    repeat (6) @(negedge clock);
    jtag.TRSTn = 1'b1;
    repeat (4) @(negedge clock);
    tck(1'b0, 1'b0, t);
    shift_dr(32'h0, 32, d);
    n_vec++; if (d !== IDC) begin n_err++; $display("FAIL trst_ir: got %h want %h", d, IDC); end
    shift_ir(5'h10, ir);
    shift_dr(m_ctrl, 32, d);
    n_vec++; if (d !== m_ctrl) begin n_err++; $display("FAIL trst_ctrl: got %h want %h", d, m_ctrl); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic        t;
    int          lows;
    shift_dr(32'hFFFF_0300, 32, d);
    repeat (50) @(negedge clock);
    n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL midframe_txd: got %b want 0", txd); end
    n_vec++; if (gfsk !== 3'd7) begin n_err++; $display("FAIL midframe_gfsk: got %0d want 7", gfsk); end
    reset = 1'b0;
    #1;
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL abort_txd: got %b want 1", txd); end
    n_vec++; if (gfsk !== 3'd0) begin n_err++; $display("FAIL abort_gfsk: got %0d want 0", gfsk); end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    m_ctrl = '0;
    lows = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (txd !== 1'b1 || gfsk !== 3'd0) lows++;
    end
    n_vec++; if (lows !== 0) begin n_err++; $display("FAIL abort_stays_idle: %0d active samples want 0", lows); end
    tck(1'b0, 1'b0, t);
    shift_dr(32'h0, 32, d);
    n_vec++; if (d !== IDC) begin n_err++; $display("FAIL abort_ir: got %h want %h", d, IDC); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ctrl_rw();
    test_bypass_reg();
    test_uart();
    test_status();
    test_modulator();
    test_simultaneous();
    test_bypass();
    test_trstn();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
